// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the power-on reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      POR_WAIT = 2'd1,
      RELEASE  = 2'd2,
      RUN      = 2'd3
   } rst_state_t;

   localparam int unsigned LOSS_CNT_W = 8;
   localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

   // Increment that sticks at LOSS_CNT_MAX instead of wrapping.
   function automatic logic [LOSS_CNT_W-1:0] loss_sat_inc(input logic [LOSS_CNT_W-1:0] v);
      return (v == LOSS_CNT_MAX) ? v : v + LOSS_CNT_W'(1);
   endfunction

endpackage

// File: rtl/reset_sequencer_lock.sv
// PLL lock qualifier: lock_ok rises on the edge that takes the LOCK_FILT-th
// consecutive high sample of pll_locked; any low sample clears it at once.
module lock_filter #(
   parameter int unsigned LOCK_FILT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   output logic lock_ok
);

   localparam int unsigned CW = $clog2(LOCK_FILT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_FILT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(LOCK_FILT);

   logic [CW-1:0] cnt;

   // Count consecutive high samples, saturating once qualified.
   always_ff @(posedge clk) begin
      if (!rst_n || !pll_locked) begin
         cnt     <= '0;
         lock_ok <= 1'b0;
      end else begin
         if (cnt != CNT_FULL) cnt <= cnt + CW'(1);
         if (cnt == CNT_LAST) lock_ok <= 1'b1;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for PLL lock, holds every channel in reset
// for POR_DELAY cycles, then releases channels 0..NUM_CH-1 STEP_DELAY apart.
// Lock loss or a soft-reset request re-asserts all channels.
// Optional build macro LOCK_FILTER_EN adds a lock qualification filter.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned POR_DELAY  = 4000000,
   parameter int unsigned STEP_DELAY = 1000,
   parameter int unsigned LOCK_FILT  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   input  logic                  soft_rst_req,
   output logic [NUM_CH-1:0]     rst_out_n,
   output logic                  all_done,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int unsigned PW = $clog2(POR_DELAY + 1);
   localparam int unsigned SW = $clog2(STEP_DELAY + 1);
   localparam int unsigned CW = $clog2(NUM_CH + 1);

   localparam logic [PW-1:0]     POR_LAST  = PW'(POR_DELAY - 1);
   localparam logic [SW-1:0]     STEP_LAST = SW'(STEP_DELAY - 1);
   // Index of the second-to-last channel: releasing the next one finishes the run.
   localparam logic [CW-1:0]     CH_PENULT = CW'((NUM_CH > 1) ? NUM_CH - 2 : 0);
   localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

   rst_state_t    state;
   logic [PW-1:0] por_cnt;
   logic [SW-1:0] step_cnt;
   logic [CW-1:0] ch_idx;   // index of the most recently released channel
   logic          lock_ok;

`ifdef LOCK_FILTER_EN
   lock_filter #(
      .LOCK_FILT (LOCK_FILT)
   ) u_lock_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .lock_ok    (lock_ok)
   );
`else
   logic unused_lock_filt;
   assign unused_lock_filt = ^LOCK_FILT;
   assign lock_ok          = pll_locked;
`endif

   // FSM, counters and registered outputs; lock loss beats soft reset beats normal flow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= HOLD;
         por_cnt       <= '0;
         step_cnt      <= '0;
         ch_idx        <= '0;
         rst_out_n     <= '0;
         all_done      <= 1'b0;
         lock_loss_cnt <= '0;
      end else if (state != HOLD && !pll_locked) begin
         state         <= HOLD;
         por_cnt       <= '0;
         step_cnt      <= '0;
         ch_idx        <= '0;
         rst_out_n     <= '0;
         all_done      <= 1'b0;
         lock_loss_cnt <= loss_sat_inc(lock_loss_cnt);
      end else if ((state == RELEASE || state == RUN) && soft_rst_req) begin
         state     <= POR_WAIT;
         por_cnt   <= '0;
         step_cnt  <= '0;
         ch_idx    <= '0;
         rst_out_n <= '0;
         all_done  <= 1'b0;
      end else begin
         unique case (state)
            HOLD: begin
               if (lock_ok) begin
                  state   <= POR_WAIT;
                  por_cnt <= '0;
               end
            end
            POR_WAIT: begin
               if (por_cnt == POR_LAST) begin
                  por_cnt   <= '0;
                  step_cnt  <= '0;
                  ch_idx    <= '0;
                  rst_out_n <= CH_ONE;
                  if (NUM_CH == 1) begin
                     state    <= RUN;
                     all_done <= 1'b1;
                  end else begin
                     state <= RELEASE;
                  end
               end else begin
                  por_cnt <= por_cnt + PW'(1);
               end
            end
            RELEASE: begin
               if (step_cnt == STEP_LAST) begin
                  step_cnt <= '0;
                  // Channels release strictly in order, so shifting in a one frees the next.
                  rst_out_n <= (rst_out_n << 1) | CH_ONE;
                  if (ch_idx == CH_PENULT) begin
                     state    <= RUN;
                     ch_idx   <= '0;
                     all_done <= 1'b1;
                  end else begin
                     ch_idx <= ch_idx + CW'(1);
                  end
               end else begin
                  step_cnt <= step_cnt + SW'(1);
               end
            end
            RUN: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on reset sequencer for the SDRAM test system. It waits for PLL lock and holds all downstream logic in reset for a programmable power-on delay. It then releases NUM_CH active-low reset channels one by one, with a fixed stagger between them: SDRAM controller first, then bus fabric, then user logic. On PLL lock loss or a soft-reset request it re-asserts every channel and restarts the sequence. It sits between the PLL and every reset consumer on the 50 MHz system clock.

## Interface
- NUM_CH, 3: number of sequenced reset outputs (1..16).
- POR_DELAY, 4000000: cycles from lock acceptance to release of channel 0 (≥1); 80 ms at 50 MHz.
- STEP_DELAY, 1000: cycles between release of channel i-1 and channel i (≥1).
- LOCK_FILT, 16: consecutive high samples of pll_locked required before lock is accepted (≥1); used only with LOCK_FILTER_EN.
- clk  in  1  system clock.
- rst_n  in  1  reset rst_n, synchronous, active-low; clock clk.
- pll_locked  in  1  PLL lock indicator, already synchronous to clk.
- soft_rst_req  in  1  one-cycle request to restart the sequence.
- rst_out_n  out  NUM_CH  per-channel reset, active-low; bit 0 is released first.
- all_done  out  1  high when every channel is released.
- lock_loss_cnt  out  8  saturating count of lock-loss aborts.

## Operation
- FSM states and transitions:
  - HOLD → POR_WAIT when lock_ok.
  - POR_WAIT → RELEASE when por_cnt == POR_DELAY-1.
  - RELEASE → RUN after the last channel is released.
- Abort on lock loss:
  - pll_locked sampled low in POR_WAIT, RELEASE or RUN sends the FSM to HOLD on that edge.
  - All rst_out_n go 0, all_done goes 0, and both counters clear.
  - lock_loss_cnt increments, saturating at 255.
  - Lock loss is always detected on the raw input; the filter never delays it.
- Soft reset:
  - soft_rst_req sampled high in RELEASE or RUN sends the FSM to POR_WAIT with por_cnt=0, all outputs asserted and all_done=0.
  - The request is ignored in HOLD and POR_WAIT.
  - Lock loss takes priority over soft_rst_req on the same edge.
- Release ordering:
  - Channel i is released (bit goes 1) only after channel i-1 is released.
  - A released channel stays high until an abort or soft reset.
- Counters:
  - por_cnt is $clog2(POR_DELAY+1) bits wide; step_cnt is $clog2(STEP_DELAY+1) bits wide.
  - ch_idx is $clog2(NUM_CH+1) bits wide.
  - Counters never wrap; each clears on every state entry.
- rst_n low, whatever the state: FSM goes to HOLD, and rst_out_n, all_done, por_cnt, step_cnt, ch_idx, lock_loss_cnt and the filter all clear.

## Timing
- Let E0 be the edge on which HOLD samples lock_ok=1. That edge sets state=POR_WAIT and por_cnt=0.
- rst_out_n[0] rises on edge E0+POR_DELAY, and the FSM enters RELEASE on the same edge.
- rst_out_n[i] rises on edge E0+POR_DELAY+i·STEP_DELAY.
- all_done rises on the same edge as rst_out_n[NUM_CH-1], and the FSM enters RUN on that edge.
- With NUM_CH=1, RELEASE lasts zero cycles: the edge that releases channel 0 also enters RUN.
- An abort or soft reset on edge Ea drives all outputs low on edge Ea itself, i.e. one cycle of latency from the sampled input.
- After a soft reset on edge Es, rst_out_n[0] rises on edge Es+POR_DELAY.
- After an abort, the sequence restarts from a fresh E0.

## Configuration
- LOCK_FILTER_EN defined:
  - lock_ok is a register that goes high on the edge taking the LOCK_FILT-th consecutive high sample of pll_locked.
  - Any low sample clears the filter counter and lock_ok on that edge.
  - E0 therefore falls LOCK_FILT+1 edges after pll_locked first rises.
- LOCK_FILTER_EN undefined: lock_ok = pll_locked combinationally, the LOCK_FILT parameter is unused, and E0 is the first edge that samples pll_locked high.

## Structure
- Package reset_seq_pkg holds:
  - typedef enum rst_state_t {HOLD, POR_WAIT, RELEASE, RUN};
  - LOSS_CNT_W=8;
  - LOSS_CNT_MAX=255.
- Sub-module lock_filter (parameter LOCK_FILT; ports clk, rst_n, pll_locked, lock_ok) is instantiated only under LOCK_FILTER_EN.
- Everything else lives in a single always block for the FSM and counters, plus output registers.

## Test plan
Bench parameters: NUM_CH=3, POR_DELAY=100, STEP_DELAY=10, LOCK_FILT=8, filter disabled unless stated.
- Raise pll_locked at edge 5 → E0=5; rst_out_n = 001 at edge 105, 011 at 115, 111 at 125; all_done rises at 125.
- Drop pll_locked at edge 110 → rst_out_n=000, all_done=0 and lock_loss_cnt=1 on edge 110; re-raise at 120 → rst_out_n[0] rises at 220.
- Pulse soft_rst_req at edge 200 while in RUN → all outputs low at edge 200, rst_out_n[0] rises at 300, lock_loss_cnt unchanged.
- Pulse soft_rst_req during POR_WAIT → ignored, timing identical to the first scenario.
- LOCK_FILTER_EN: pll_locked high for 7 cycles, low 1, then steady high from edge 20 → no release before the filter qualifies; E0=28, rst_out_n[0] rises at 128.
- 300 lock drops while in RUN → lock_loss_cnt saturates at 255; assert rst_n for one cycle mid-RELEASE → everything clears to 0 on that edge.
